// File: rtl/vending_pkg.sv
// vending_pkg: constants and FSM encoding shared by the vending blocks
//   PRICE          sale threshold (also used by the seller block)
//   COIN_1/COIN_2  coin_den encodings for 1-unit and 2-unit coins
//   state_t        payout FSM states
package vending_pkg;
  localparam int PRICE = 5;
  localparam logic COIN_1 = 1'b0;
  localparam logic COIN_2 = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, REL = 2'd2} state_t;
endpackage

// File: rtl/change_fifo.sv
// change_fifo: show-ahead FIFO of pending change amounts
//   clk, clr      clock, async active-high reset (empties the FIFO)
//   push, din     write din unless full (a push into a full FIFO is dropped)
//   pop, dout     dout is the head entry; pop advances it unless empty
//   full, empty   occupancy flags
//   count         occupancy, 0..DEPTH
module change_fifo #(
  parameter int W = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: detects sales from the seller and pays the change out coin by coin
//   clk, clr              clock, async active-high reset
//   val, ex               seller amount and change owed (ex valid in the sale cycle)
//   hopper_ack            hopper has ejected the requested coin (level)
//   coin_req, coin_den    coin request (level) and denomination (0 = 1-unit, 1 = 2-unit)
//   vend                  one-cycle pulse per sale
//   busy, ovf, pending    payout activity, sticky change-dropped flag, FIFO occupancy
module change_dispenser import vending_pkg::*; #(
  parameter int PRICE = vending_pkg::PRICE,
  parameter int W = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [W-1:0]           val,
  input  logic [W-1:0]           ex,
  input  logic                   hopper_ack,
  output logic                   coin_req,
  output logic                   coin_den,
  output logic                   vend,
  output logic                   busy,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] pending
);
  state_t state;
  logic ge, sale_d, sale, push, pop, full, empty;
  logic [W-1:0] rem, dout;
  assign ge = val >= W'(PRICE);
  assign sale = ge && !sale_d;
  assign push = sale && ex != '0;
  // pop only where the FSM loads rem: from IDLE, or from REL once the current amount is done
  assign pop = !empty && (state == IDLE || (state == REL && !hopper_ack && rem == '0));
  assign busy = state != IDLE || pending != '0;
  change_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .clr(clr), .push(push), .pop(pop), .din(ex),
    .dout(dout), .full(full), .empty(empty), .count(pending)
  );
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      sale_d <= 1'b0;
      vend <= 1'b0;
      ovf <= 1'b0;
    end else begin
      sale_d <= ge;
      vend <= sale;
      if (push && full) ovf <= 1'b1;
    end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= IDLE;
      rem <= '0;
      coin_req <= 1'b0;
      coin_den <= COIN_1;
    end else
      case (state)
        IDLE:
          if (pop) begin
            rem <= dout;
            coin_den <= (dout >= W'(2)) ? COIN_2 : COIN_1;
            coin_req <= 1'b1;
            state <= REQ;
          end
        REQ:
          if (hopper_ack) begin
            rem <= rem - ((coin_den == COIN_2) ? W'(2) : W'(1));
            coin_req <= 1'b0;
            state <= REL;
          end
        REL:
          if (!hopper_ack) begin
            if (rem != '0) begin
              coin_den <= (rem >= W'(2)) ? COIN_2 : COIN_1;
              coin_req <= 1'b1;
              state <= REQ;
            end else if (pop) begin
              rem <= dout;
              coin_den <= (dout >= W'(2)) ? COIN_2 : COIN_1;
              coin_req <= 1'b1;
              state <= REQ;
            end else
              state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule
